// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point compare pipeline: default field
// widths, the compare-result encoding and the zero-detect helper.
package fp_pkg;

    localparam int DEF_EXP_W  = 4;
    localparam int DEF_FRAC_W = 8;
    // Wide enough for the largest legal {exp,frac} (11 + 52 bits).
    localparam int ZD_W       = 64;

    typedef enum logic [1:0] {
        GT = 2'd0,
        EQ = 2'd1,
        LT = 2'd2
    } cmp_res_t;

    function automatic logic is_zero(input logic [ZD_W-1:0] exp_frac);
        return exp_frac == '0;
    endfunction

endpackage

// File: rtl/fp_mag_cmp.sv
// Unsigned magnitude compare of two concatenated {exp,frac} words.
module fp_mag_cmp #(
    parameter int W = 12
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         mag_gt,
    output logic         mag_eq
);

    assign mag_gt = (a > b);
    assign mag_eq = (a == b);

endmodule

// File: rtl/fp_cmp_pipe.sv
// Two-stage sign/magnitude float comparator with saturating gt counter.
// Define FP_CMP_ZERO_EQ_EN to make +0 and -0 compare equal.
module fp_cmp_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W  = DEF_EXP_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign1,
    input  logic              sign2,
    input  logic [EXP_W-1:0]  exp1,
    input  logic [EXP_W-1:0]  exp2,
    input  logic [FRAC_W-1:0] frac1,
    input  logic [FRAC_W-1:0] frac2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              gt,
    output logic              eq,
    output logic              lt,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  gt_cnt
);

    localparam int MAG_W = EXP_W + FRAC_W;

    logic     mag_gt, mag_eq;
    logic     s1_valid, s1_sign1, s1_sign2, s1_mag_gt, s1_mag_eq;
    logic     s2_valid;
    logic     s1_ready, s2_ready;
    cmp_res_t s2_res, res_next;

    fp_mag_cmp #(.W(MAG_W)) u_mag (
        .a      ({exp1, frac1}),
        .b      ({exp2, frac2}),
        .mag_gt (mag_gt),
        .mag_eq (mag_eq)
    );

`ifdef FP_CMP_ZERO_EQ_EN
    logic s1_both_zero;
    logic both_zero_in;
    assign both_zero_in = is_zero(ZD_W'({exp1, frac1})) && is_zero(ZD_W'({exp2, frac2}));
`endif

    // Handshake: a stage moves on valid && ready; a stage is ready when empty
    // or when the stage after it is taking its contents this cycle.
    assign s2_ready = !s2_valid || out_ready;
    assign s1_ready = !s1_valid || s2_ready;
    assign in_ready = s1_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_ready) s1_valid <= in_valid;
            if (s2_ready) s2_valid <= s1_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && s1_ready) begin
            s1_sign1  <= sign1;
            s1_sign2  <= sign2;
            s1_mag_gt <= mag_gt;
            s1_mag_eq <= mag_eq;
`ifdef FP_CMP_ZERO_EQ_EN
            s1_both_zero <= both_zero_in;
`endif
        end
        if (s1_valid && s2_ready) s2_res <= res_next;
    end

    // For two negatives the larger magnitude is the smaller number.
    always_comb begin
        res_next = LT;
        if (s1_sign1 != s1_sign2) res_next = s1_sign1 ? LT : GT;
        else if (s1_mag_eq)       res_next = EQ;
        else if (s1_mag_gt)       res_next = s1_sign1 ? LT : GT;
        else                      res_next = s1_sign1 ? GT : LT;
`ifdef FP_CMP_ZERO_EQ_EN
        if (s1_both_zero) res_next = EQ;
`endif
    end

    assign out_valid = s2_valid;
    assign gt        = s2_valid && (s2_res == GT);
    assign eq        = s2_valid && (s2_res == EQ);
    assign lt        = s2_valid && (s2_res == LT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gt_cnt <= '0;
        end else if (cnt_clr) begin
            gt_cnt <= '0;
        end else if (out_valid && out_ready && gt && (gt_cnt != '1)) begin
            gt_cnt <= gt_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fp_cmp_pipe.sv
// Randomised and directed bench for fp_cmp_pipe against a numeric reference
// model; honours FP_CMP_ZERO_EQ_EN the same way the design does.
module tb_fp_cmp_pipe;

    localparam int EXP_W  = 4;
    localparam int FRAC_W = 8;
    localparam int CNT_W  = 4;
    localparam int OP_W   = 1 + EXP_W + FRAC_W;
`ifdef FP_CMP_ZERO_EQ_EN
    localparam bit ZERO_EQ = 1'b1;
`else
    localparam bit ZERO_EQ = 1'b0;
`endif

    logic              clk, reset_n;
    logic              in_valid, in_ready, out_valid, out_ready;
    logic              sign1, sign2, gt, eq, lt, cnt_clr;
    logic [EXP_W-1:0]  exp1, exp2;
    logic [FRAC_W-1:0] frac1, frac2;
    logic [CNT_W-1:0]  gt_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int model_cnt = 0;
    bit no_bp    = 1'b0;
    bit prev_stall = 1'b0;
    bit rand_done  = 1'b0;
    logic [2:0]  prev_res;
    logic [34:0] exp_q[$];

    fp_cmp_pipe #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .sign1(sign1), .sign2(sign2),
        .exp1(exp1), .exp2(exp2),
        .frac1(frac1), .frac2(frac2),
        .out_valid(out_valid), .out_ready(out_ready),
        .gt(gt), .eq(eq), .lt(lt),
        .cnt_clr(cnt_clr), .gt_cnt(gt_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: turn each operand into a signed integer value and compare numbers.
    function automatic logic [2:0] model(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
        longint va, vb;
        va = longint'(a[FRAC_W-1:0]) << a[OP_W-2:FRAC_W];
        vb = longint'(b[FRAC_W-1:0]) << b[OP_W-2:FRAC_W];
        if (a[OP_W-1]) va = -va;
        if (b[OP_W-1]) vb = -vb;
        if (a[OP_W-2:0] == 0 && b[OP_W-2:0] == 0) begin
            if (ZERO_EQ || a[OP_W-1] == b[OP_W-1]) return 3'b010;
            return a[OP_W-1] ? 3'b001 : 3'b100;
        end
        if (va > vb)  return 3'b100;
        if (va == vb) return 3'b010;
        return 3'b001;
    endfunction

    // ---------------- scoreboard / compare process ----------------
    always @(negedge clk) begin
        logic [34:0] e;
        if (!reset_n) begin
            exp_q.delete();
            model_cnt = 0;
            prev_stall = 1'b0;
            chk("rst_outputs", {out_valid, gt, eq, lt, in_ready}, 5'b00001);
            chk("rst_cnt", gt_cnt, 0);
        end else begin
            if (prev_stall) chk("stall_hold", {out_valid, gt, eq, lt}, {1'b1, prev_res});
            if (out_valid) chk("onehot", 64'($countones({gt, eq, lt})), 1);
            chk("gt_cnt", gt_cnt, 64'(model_cnt));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", {gt, eq, lt}, e[2:0]);
                    if (no_bp) chk("latency", 64'(cyc - int'(e[34:3])), 2);
                    if (e[2] && model_cnt < (1 << CNT_W) - 1) model_cnt++;
                end
            end
            if (cnt_clr) model_cnt = 0;
            if (no_bp) chk("in_ready_flow", in_ready, 1);
            if (in_valid && in_ready)
                exp_q.push_back({cyc[31:0], model({sign1, exp1, frac1}, {sign2, exp2, frac2})});
            prev_stall = out_valid && !out_ready;
            prev_res   = {gt, eq, lt};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_op(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
        int waits = 0;
        {sign1, exp1, frac1} = a;
        {sign2, exp2, frac2} = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) chk("send_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [OP_W-1:0] rand_op();
        logic [OP_W-1:0] op;
        if ($urandom_range(0, 7) == 0)
            op = {1'($urandom_range(0, 1)), {(OP_W-1){1'b0}}};
        else
            op = {1'($urandom_range(0, 1)), EXP_W'($urandom_range(0, 15)),
                  1'b1, (FRAC_W-1)'($urandom_range(0, 127))};
        return op;
    endfunction

    function automatic logic [OP_W-1:0] rand_op2(input logic [OP_W-1:0] a);
        if ($urandom_range(0, 3) == 0) return {1'($urandom_range(0, 1)), a[OP_W-2:0]};
        return rand_op();
    endfunction

    // Pipeline must be empty on entry: checks the result lands exactly two cycles on.
    task automatic directed(input string name, input logic [OP_W-1:0] a,
                            input logic [OP_W-1:0] b, input logic [2:0] exp_res);
        send_op(a, b);
        @(negedge clk);
        chk({name, "_lat1"}, out_valid, 0);
        @(negedge clk);
        chk({name, "_valid"}, out_valid, 1);
        chk({name, "_res"}, {gt, eq, lt}, exp_res);
        @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [OP_W-1:0] a, b;
        int accepted;
        bit acc_flag;
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        {sign1, exp1, frac1, sign2, exp2, frac2} = '0;
        idle(3);
        reset_n = 1'b1;
        no_bp = 1'b1;

        directed("pos_gt", {1'b0, 4'hC, 8'hC0}, {1'b0, 4'hC, 8'h80}, 3'b100);
        @(negedge clk);
        chk("cnt_after_gt", gt_cnt, 1);
        idle(1);
        directed("neg_lt", {1'b1, 4'hC, 8'hC0}, {1'b1, 4'hC, 8'h80}, 3'b001);
        directed("same_eq", {1'b1, 4'h3, 8'hA5}, {1'b1, 4'h3, 8'hA5}, 3'b010);
        directed("mixed_gt", {1'b0, 4'h1, 8'h80}, {1'b1, 4'hF, 8'hFF}, 3'b100);
        directed("zero", {1'b0, 12'h000}, {1'b1, 12'h000}, ZERO_EQ ? 3'b010 : 3'b100);

        // back-to-back flow
        repeat (4) begin
            a = rand_op();
            send_op(a, rand_op2(a));
        end
        idle(4);
        chk("b2b_drained", 64'(exp_q.size()), 0);

        // backpressure: only two pairs fit
        no_bp = 1'b0;
        out_ready = 1'b0;
        accepted = 0;
        a = rand_op(); b = rand_op2(a);
        {sign1, exp1, frac1} = a; {sign2, exp2, frac2} = b; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            acc_flag = in_ready;
            if (acc_flag) accepted++;
            @(posedge clk);
            #1;
            if (acc_flag) begin
                a = rand_op(); b = rand_op2(a);
                {sign1, exp1, frac1} = a; {sign2, exp2, frac2} = b;
            end
        end
        chk("stall_accepted", 64'(accepted), 2);
        chk("stall_in_ready", in_ready, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        idle(5);
        chk("stall_drained", 64'(exp_q.size()), 0);

        // counter saturation at CNT_W=4
        cnt_clr = 1'b1; idle(1); cnt_clr = 1'b0;
        repeat (15) send_op({1'b0, 4'h5, 8'h90}, {1'b0, 4'h2, 8'h90});
        idle(4);
        @(negedge clk);
        chk("cnt_full", gt_cnt, 4'hF);
        idle(1);
        send_op({1'b0, 4'h5, 8'h90}, {1'b1, 4'h2, 8'h90});
        idle(4);
        @(negedge clk);
        chk("cnt_sat", gt_cnt, 4'hF);
        idle(1);

        // clear coincident with a gt delivery
        send_op({1'b0, 4'h7, 8'hF0}, {1'b0, 4'h7, 8'h81});
        idle(1);
        cnt_clr = 1'b1;
        @(negedge clk);
        chk("clr_with_gt_xfer", out_valid && out_ready && gt, 1);
        idle(1);
        cnt_clr = 1'b0;
        @(negedge clk);
        chk("clr_priority", gt_cnt, 0);
        idle(1);

        // reset with two pairs in flight
        send_op({1'b0, 4'h9, 8'hC0}, {1'b0, 4'h1, 8'h80});
        send_op({1'b1, 4'h9, 8'hC0}, {1'b0, 4'h1, 8'h80});
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_reset_quiet", out_valid, 0);
        end
        idle(1);

        // randomised traffic with random backpressure and clears
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) idle(1);
                    a = rand_op();
                    send_op(a, rand_op2(a));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                    cnt_clr   = ($urandom_range(0, 31) == 0);
                end
            end
        join
        out_ready = 1'b1;
        cnt_clr = 1'b0;
        idle(8);
        chk("rand_drained", 64'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
